// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: phase state codes and phase-timer clock-frequency codes.
package wm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned FREQ_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_FILL  = 3'b001,
    ST_WASH  = 3'b010,
    ST_RINSE = 3'b011,
    ST_SPIN  = 3'b100,
    ST_PAUSE = 3'b101
  } wm_state_e;

  typedef enum logic [FREQ_W-1:0] {
    FREQ_1MHZ = 2'b00,
    FREQ_2MHZ = 2'b01,
    FREQ_4MHZ = 2'b10,
    FREQ_8MHZ = 2'b11
  } wm_freq_e;

  // Phases that run against the phase timer and can be advanced by timer_done.
  function automatic logic is_timed_phase(input wm_state_e s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/wash_controller.sv
// Washing-machine cycle sequencer: walks fill/wash/rinse/spin phases against an external
// phase timer, with optional second wash+rinse pass, lid pause during spin and cancel.
module wash_controller
  import wm_pkg::*;
#(
  parameter logic [FREQ_W-1:0] FREQ_SEL = FREQ_1MHZ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coin_in,
  input  logic               double_wash,
  input  logic               lid_open,
  input  logic               cancel,
  input  logic               timer_done,
  output logic [STATE_W-1:0] state,
  output logic               start_timer,
  output logic [FREQ_W-1:0]  clk_freq,
  output logic               wash_done,
  output logic               busy,
  output logic               second_pass
);

  wm_state_e state_q, state_d;
  logic      start_q, start_d;
  logic      done_q, done_d;
  logic      busy_q, busy_d;
  logic      sp_q, sp_d;
  logic      dw_q, dw_d;
  logic      armed_q, armed_d;
  logic      advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sp_q    <= 1'b0;
      dw_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sp_q    <= sp_d;
      dw_q    <= dw_d;
      armed_q <= armed_d;
    end
  end

  // Priority: cancel > armed timer_done > lid_open. Lid pause keeps armed so the
  // resumed spin phase can still finish on the same timer run.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    sp_d    = sp_q;
    dw_d    = dw_q;
    armed_d = armed_q | start_q;
    advance = timer_done & armed_q;

    if (state_q == ST_IDLE) begin
      if (coin_in) begin
        state_d = ST_FILL;
        start_d = 1'b1;
        dw_d    = double_wash;
        sp_d    = 1'b0;
        armed_d = 1'b0;
      end
    end else if (cancel || !(is_timed_phase(state_q) || state_q == ST_PAUSE)) begin
      state_d = ST_IDLE;
      dw_d    = 1'b0;
      sp_d    = 1'b0;
      armed_d = 1'b0;
    end else if (state_q == ST_PAUSE) begin
      if (!lid_open) state_d = ST_SPIN;
    end else if (advance) begin
      armed_d = 1'b0;
      start_d = 1'b1;
      case (state_q)
        ST_FILL: state_d = ST_WASH;
        ST_WASH: state_d = ST_RINSE;
        ST_RINSE: begin
          if (dw_q && !sp_q) begin
            state_d = ST_WASH;
            sp_d    = 1'b1;
          end else begin
            state_d = ST_SPIN;
            sp_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          start_d = 1'b0;
          done_d  = 1'b1;
          dw_d    = 1'b0;
          sp_d    = 1'b0;
        end
      endcase
    end else if (state_q == ST_SPIN && lid_open) begin
      state_d = ST_PAUSE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign state       = state_q;
  assign start_timer = start_q;
  assign wash_done   = done_q;
  assign busy        = busy_q;
  assign second_pass = sp_q;
  assign clk_freq    = FREQ_SEL;

endmodule

// File: doc/wash_controller.md
WASH_CONTROLLER -- requirements
Module: wash_controller

Interface
REQ-001 Parameter FREQ_SEL, default 2'b00, is the clock-frequency code driven to the phase timer (00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz).
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 coin_in  input  1  coin accepted; starts a cycle when in Idle.
REQ-005 double_wash  input  1  request for a second wash+rinse pass; sampled at coin acceptance.
REQ-006 lid_open  input  1  lid-open sensor; level.
REQ-007 cancel  input  1  abort the current cycle; level.
REQ-008 timer_done  input  1  phase-timer Finished level.
REQ-009 state  output  3  current phase, driven to the timer's state input.
REQ-010 start_timer  output  1  one-cycle pulse that rearms the phase timer.
REQ-011 clk_freq  output  2  constant FREQ_SEL.
REQ-012 wash_done  output  1  one-cycle pulse on normal cycle completion.
REQ-013 busy  output  1  high whenever state != Idle.
REQ-014 second_pass  output  1  high while the second wash/rinse pass is executing.

Function
REQ-015 State encoding: Idle=000, Filling_water=001, Washing=010, Rinsing=011, Spinning=100, Pause=101; codes 110 and 111 go to Idle on the next clock.
REQ-016 In Idle, coin_in=1 moves to Filling_water, latches double_wash into dw_req, clears second_pass, and pulses start_timer in the same edge.
REQ-017 Every transition into Filling_water, Washing, Rinsing or Spinning from another active or idle state pulses start_timer for exactly one cycle.
REQ-018 An internal armed bit sets one cycle after any start_timer pulse and clears on every phase transition.
REQ-019 timer_done is ignored while armed=0, so a stale Finished level from the prior phase cannot advance the FSM.
REQ-020 Phase advance on timer_done=1 with armed=1 follows this order:
- Filling_water -> Washing
- Washing -> Rinsing
- Rinsing -> Washing, setting second_pass, if dw_req=1 and second_pass=0; otherwise Rinsing -> Spinning
- Spinning -> Idle, pulsing wash_done
REQ-021 In Spinning, lid_open=1 moves to Pause; in Pause, lid_open=0 returns to Spinning with no start_timer pulse, so the timer resumes its count; lid_open is ignored in every other state.
REQ-022 Priority in a cycle: cancel > timer_done > lid_open; timer_done and lid_open together in Spinning go to Idle with wash_done.
REQ-023 cancel=1 in any non-Idle state, including Pause, goes to Idle next clock with no wash_done pulse, and clears dw_req, second_pass and armed.
REQ-024 coin_in and double_wash are ignored outside Idle; cancel and timer_done are ignored in Idle.
REQ-025 start_timer and wash_done are never high in the same cycle, and neither is high for two consecutive cycles.
REQ-026 All outputs are registered; state-change latency is one clock from the qualifying input.

Reset
REQ-027 On rst_n=0, asynchronously: state=Idle, start_timer=0, wash_done=0, busy=0, second_pass=0, dw_req=0, armed=0; clk_freq=FREQ_SEL at all times.
REQ-028 Reset asserted mid-cycle abandons the cycle with no wash_done; after release the block waits in Idle for coin_in.

Structure
REQ-029 State codes and frequency codes reside in shared package wm_pkg, also used by the phase timer.
REQ-030 The block is a single FSM with no sub-module; the phase timer is instantiated beside it in the top-level washing-machine wrapper.

Verification
REQ-031 Reset, coin_in=1 for 1 cycle, double_wash=0, timer_done pulsed 2 cycles after each start -> states 001,010,011,100,000; 4 start_timer pulses; 1 wash_done.
REQ-032 double_wash=1 at coin -> sequence 001,010,011,010,011,100,000; second_pass high during the second 010/011; 6 start_timer pulses.
REQ-033 In Spinning, lid_open=1 for 5 cycles -> Pause for 5 cycles, then Spinning with no start_timer pulse; lid_open in Washing -> no effect.
REQ-034 timer_done held high continuously from coin -> each phase lasts exactly 2 cycles (start, arm), with no skipped phase.
REQ-035 cancel=1 in Pause -> Idle next clock, no wash_done; a following coin_in restarts at 001 with a start_timer pulse.
REQ-036 rst_n low mid-Rinsing -> immediate Idle with all outputs 0; timer_done and lid_open together in Spinning -> Idle with wash_done=1.
